// File: rtl/wall_pkg.sv
// Shared types for the wall scroller: FSM states, the per-slot wall record and
// default geometry. Imported by wall_scroller.
package wall_pkg;

  localparam int WALL_X_W     = 8;
  localparam int WALL_H_W     = 8;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_BIRD_X   = 40;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_UPDATE    = 2'd2,
    ST_SPAWN     = 2'd3
  } wall_state_e;

  typedef struct packed {
    logic                valid;
    logic [WALL_X_W-1:0] x;
    logic [WALL_H_W-1:0] h;
  } wall_t;

  // Unsigned ceiling on the incoming generator word.
  function automatic logic [WALL_H_W-1:0] clamp_height(
    input logic [WALL_H_W-1:0] h,
    input logic [WALL_H_W-1:0] lim
  );
    logic [WALL_H_W-1:0] r;
    if (h > lim) begin
      r = lim;
    end else begin
      r = h;
    end
    return r;
  endfunction

endpackage

// File: rtl/wall_free_slot_finder.sv
// Combinational priority encoder: lowest-index slot whose valid bit is clear,
// plus a flag saying whether any slot is free at all.
module wall_free_slot_finder #(
  parameter  int NUM_WALLS = 4,
  localparam int IDX_W     = $clog2(NUM_WALLS)
) (
  input  logic [NUM_WALLS-1:0] valid_vec,
  output logic [IDX_W-1:0]     free_idx,
  output logic                 any_free
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_WALLS - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end else begin
        free_idx = free_idx;
      end
    end
  end

endmodule

// File: rtl/wall_scroller.sv
// Wall pool: scrolls, retires and spawns walls once per frame tick.
// Optional build macro WALL_SCORE_COUNT_EN adds a saturating 8-bit score output.
module wall_scroller
  import wall_pkg::*;
#(
  parameter  int NUM_WALLS = 4,
  parameter  int X_W       = WALL_X_W,
  parameter  int H_W       = WALL_H_W,
  parameter  int SCREEN_W  = DEF_SCREEN_W,
  parameter  int SPEED     = 2,
  parameter  int SPAWN_GAP = 40,
  parameter  int BIRD_X    = DEF_BIRD_X,
  parameter  int MAX_GAP_Y = 93,
  localparam int IDX_W     = $clog2(NUM_WALLS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             restart,
  input  logic             frame_tick,
  input  logic [H_W-1:0]   height_in,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [X_W-1:0]   rd_x,
  output logic [H_W-1:0]   rd_h,
  output logic             busy,
  output logic             score_pulse,
  output logic             overrun
`ifdef WALL_SCORE_COUNT_EN
  ,
  output logic [7:0]       score
`endif
);

  localparam logic [WALL_X_W-1:0] SPEED_X  = WALL_X_W'(SPEED);
  localparam logic [WALL_X_W-1:0] BIRD_XV  = WALL_X_W'(BIRD_X);
  localparam logic [WALL_X_W-1:0] SPAWN_X  = WALL_X_W'(SCREEN_W - 1);
  localparam logic [WALL_H_W-1:0] MAX_H    = WALL_H_W'(MAX_GAP_Y);
  localparam logic [X_W-1:0]      GAP_CNT  = X_W'(SPAWN_GAP);
  localparam logic [X_W:0]        GAP_WIDE = (X_W+1)'(SPAWN_GAP);
  localparam logic [X_W:0]        SPD_WIDE = (X_W+1)'(SPEED);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_WALLS - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);

  wall_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  wall_t                slots_q [NUM_WALLS];
  wall_t                slots_d [NUM_WALLS];
  logic [X_W-1:0]       spawn_cnt_q, spawn_cnt_d;
  logic                 busy_q, busy_d;
  logic                 score_pulse_q, score_pulse_d;
  logic                 overrun_q, overrun_d;

  logic [NUM_WALLS-1:0] valid_vec_s;
  logic [IDX_W-1:0]     free_idx_s;
  logic                 any_free_s;
  wall_t                cur_s;
  logic [WALL_X_W-1:0]  new_x_s;
  logic [X_W:0]         cnt_sum_s;
  logic [X_W-1:0]       cnt_sat_s;

  // Gather slot valid bits for the free-slot search.
  always_comb begin
    valid_vec_s = '0;
    for (int i = 0; i < NUM_WALLS; i++) begin
      valid_vec_s[i] = slots_q[i].valid;
    end
  end

  wall_free_slot_finder #(
    .NUM_WALLS (NUM_WALLS)
  ) u_free_slot (
    .valid_vec (valid_vec_s),
    .free_idx  (free_idx_s),
    .any_free  (any_free_s)
  );

  // Next-state, slot update and spawn decision; restart overrides everything.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    slots_d       = slots_q;
    spawn_cnt_d   = spawn_cnt_q;
    score_pulse_d = 1'b0;
    overrun_d     = overrun_q;
    cur_s         = slots_q[idx_q];
    new_x_s       = cur_s.x - SPEED_X;
    cnt_sum_s     = {1'b0, spawn_cnt_q} + SPD_WIDE;
    if (cnt_sum_s >= GAP_WIDE) begin
      cnt_sat_s = GAP_CNT;
    end else begin
      cnt_sat_s = cnt_sum_s[X_W-1:0];
    end

    if (restart) begin
      for (int i = 0; i < NUM_WALLS; i++) begin
        slots_d[i].valid = 1'b0;
      end
      spawn_cnt_d = GAP_CNT;
      idx_d       = '0;
      overrun_d   = 1'b0;
      if (enable) begin
        state_d = ST_WAIT_TICK;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      // A tick that lands mid-pass is lost; remember that it happened.
      if (frame_tick && ((state_q == ST_UPDATE) || (state_q == ST_SPAWN))) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_d = ST_WAIT_TICK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_TICK: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (frame_tick) begin
            state_d = ST_UPDATE;
            idx_d   = '0;
          end else begin
            state_d = ST_WAIT_TICK;
          end
        end
        ST_UPDATE: begin
          if (cur_s.valid) begin
            if (cur_s.x < SPEED_X) begin
              slots_d[idx_q].valid = 1'b0;
            end else begin
              slots_d[idx_q].x = new_x_s;
              if ((cur_s.x >= BIRD_XV) && (new_x_s < BIRD_XV)) begin
                score_pulse_d = 1'b1;
              end else begin
                score_pulse_d = 1'b0;
              end
            end
          end else begin
            slots_d[idx_q] = cur_s;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_SPAWN;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
        ST_SPAWN: begin
          // Slot valids already reflect this pass's retirements here.
          if ((cnt_sat_s == GAP_CNT) && any_free_s) begin
            slots_d[free_idx_s] = '{valid: 1'b1,
                                    x:     SPAWN_X,
                                    h:     clamp_height(WALL_H_W'(height_in), MAX_H)};
            spawn_cnt_d = '0;
          end else begin
            spawn_cnt_d = cnt_sat_s;
          end
          if (enable) begin
            state_d = ST_WAIT_TICK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_UPDATE) || (state_d == ST_SPAWN);
  end

  // State and slot registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      spawn_cnt_q   <= GAP_CNT;
      busy_q        <= 1'b0;
      score_pulse_q <= 1'b0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < NUM_WALLS; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      spawn_cnt_q   <= spawn_cnt_d;
      busy_q        <= busy_d;
      score_pulse_q <= score_pulse_d;
      overrun_q     <= overrun_d;
      slots_q       <= slots_d;
    end
  end

  assign rd_valid    = slots_q[rd_idx].valid;
  assign rd_x        = X_W'(slots_q[rd_idx].x);
  assign rd_h        = H_W'(slots_q[rd_idx].h);
  assign busy        = busy_q;
  assign score_pulse = score_pulse_q;
  assign overrun     = overrun_q;

`ifdef WALL_SCORE_COUNT_EN
  logic [7:0] score_q, score_d;

  // Score advances on the same edge the pulse is raised; saturates at 255.
  always_comb begin
    score_d = score_q;
    if (restart) begin
      score_d = 8'd0;
    end else if (score_pulse_d && (score_q != 8'hFF)) begin
      score_d = score_q + 8'd1;
    end else begin
      score_d = score_q;
    end
  end

  // Score register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      score_q <= 8'd0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_wall_scroller.sv
// Directed bench for wall_scroller: a pass-level model of the wall pool is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_wall_scroller;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       restart = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] height_in = 8'd0;
  logic [1:0] rd_idx = 2'd0;
  logic       rd_valid;
  logic [7:0] rd_x;
  logic [7:0] rd_h;
  logic       busy;
  logic       score_pulse;
  logic       overrun;
`ifdef WALL_SCORE_COUNT_EN
  logic [7:0] score;
`endif

  wall_scroller dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .restart     (restart),
    .frame_tick  (frame_tick),
    .height_in   (height_in),
    .rd_idx      (rd_idx),
    .rd_valid    (rd_valid),
    .rd_x        (rd_x),
    .rd_h        (rd_h),
    .busy        (busy),
    .score_pulse (score_pulse),
    .overrun     (overrun)
`ifdef WALL_SCORE_COUNT_EN
    ,
    .score       (score)
`endif
  );

  always #5 clk = ~clk;

  localparam int SPEED = 2;
  localparam int GAP   = 40;
  localparam int BIRD  = 40;
  localparam int SPAWN = 159;
  localparam int MAXH  = 93;
  localparam int PASS  = 5;

  int checks = 0;
  int errors = 0;
  int pulse_seen = 0;
  int busy_seen = 0;

  // Model state: the pool after each pass, plus the timing of what is visible.
  int m_v [4];
  int m_x [4];
  int m_h [4];
  int m_cnt, m_busy_left, m_running, m_pend, m_pulse, m_overrun, m_score;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 0; m_x[i] = 0; m_h[i] = 0;
    end
    m_cnt = GAP; m_busy_left = 0; m_running = 0; m_pend = 0;
    m_pulse = 0; m_overrun = 0; m_score = 0;
  endtask

  // One clock edge of the model; inputs are those seen at this edge.
  task automatic model_edge();
    int f;
    m_pulse = m_pend & 1;
    m_pend  = m_pend >> 1;
    if (restart) begin
      for (int i = 0; i < 4; i++) m_v[i] = 0;
      m_cnt = GAP; m_busy_left = 0; m_pend = 0; m_pulse = 0;
      m_overrun = 0; m_score = 0; m_running = enable ? 1 : 0;
    end else begin
      if (frame_tick && m_busy_left > 0) m_overrun = 1;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_cnt = (m_cnt + SPEED > GAP) ? GAP : m_cnt + SPEED;
          if (m_cnt >= GAP) begin
            f = -1;
            for (int i = 3; i >= 0; i--) if (m_v[i] == 0) f = i;
            if (f >= 0) begin
              m_v[f] = 1; m_x[f] = SPAWN;
              m_h[f] = (int'(height_in) > MAXH) ? MAXH : int'(height_in);
              m_cnt = 0;
            end
          end
          m_running = enable ? 1 : 0;
        end
      end else if (m_running == 0) begin
        m_running = enable ? 1 : 0;
      end else if (!enable) begin
        m_running = 0;
      end else if (frame_tick) begin
        for (int i = 0; i < 4; i++) begin
          if (m_v[i] != 0) begin
            if (m_x[i] < SPEED) m_v[i] = 0;
            else begin
              if (m_x[i] >= BIRD && m_x[i] - SPEED < BIRD) m_pend = m_pend | (1 << i);
              m_x[i] = m_x[i] - SPEED;
            end
          end
        end
        m_busy_left = PASS;
      end
      if (m_pulse != 0 && m_score < 255) m_score++;
    end
  endtask

  task automatic compare_cycle();
    busy_seen  += int'(busy);
    pulse_seen += int'(score_pulse);
    chk("busy", int'(busy), (m_busy_left > 0) ? 1 : 0);
    chk("score_pulse", int'(score_pulse), m_pulse);
    chk("overrun", int'(overrun), m_overrun);
`ifdef WALL_SCORE_COUNT_EN
    chk("score", int'(score), m_score);
`endif
    if (m_busy_left == 0) begin
      chk("rd_valid", int'(rd_valid), m_v[rd_idx]);
      if (m_v[rd_idx] != 0) begin
        chk("rd_x", int'(rd_x), m_x[rd_idx]);
        chk("rd_h", int'(rd_h), m_h[rd_idx]);
      end
    end
  endtask

  // Advance one clock; inputs change at the negedge after the compare.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1 rd_idx = rd_idx + 2'd1;
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (6) step();
  endtask

  task automatic read_slot(input int i, output int v, output int x, output int h);
    rd_idx = 2'(i);
    #1;
    v = int'(rd_valid); x = int'(rd_x); h = int'(rd_h);
  endtask

  initial begin
    int v, x, h, p0, b0, nvalid;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulse", int'(score_pulse), 0);
    chk("rst_overrun", int'(overrun), 0);
    for (int i = 0; i < 4; i++) begin
      read_slot(i, v, x, h);
      chk("rst_valid", v, 0);
      chk("rst_x", x, 0);
      chk("rst_h", h, 0);
    end
    resetn = 1'b1;
    enable = 1'b1;
    height_in = 8'd50;
    step();

    // Frame 0: first tick spawns at once.
    b0 = busy_seen;
    frame();
    chk("first_pass_busy_cycles", busy_seen - b0, 5);
    read_slot(0, v, x, h);
    chk("f0_valid", v, 1);
    chk("f0_x", x, 159);
    chk("f0_h", h, 50);
    chk("model_cnt_after_spawn", m_cnt, 0);
    step();

    for (int f = 1; f <= 80; f++) begin
      if (f == 20) height_in = 8'd200;
      else if (f == 40) height_in = 8'd93;
      else if (f == 60) height_in = 8'd94;
      else if (f == 80) height_in = 8'd77;
      p0 = pulse_seen;
      frame();
      if (f == 20) begin
        read_slot(1, v, x, h);
        chk("f20_clamped_h", h, 93);
        chk("f20_spawn_x", x, 159);
        step();
        read_slot(0, v, x, h);
        chk("f20_slot0_x", x, 119);
      end
      if (f == 59) chk("pulses_before_60", pulse_seen, 0);
      if (f == 60) begin
        chk("f60_pulses", pulse_seen - p0, 1);
        read_slot(0, v, x, h);
        chk("f60_slot0_x", x, 39);
        chk("model_f60_x", m_x[0], 39);
      end
      if (f == 80) begin
        chk("f80_pulses", pulse_seen - p0, 1);
        read_slot(0, v, x, h);
        chk("f80_respawn_valid", v, 1);
        chk("f80_respawn_x", x, 159);
        chk("f80_respawn_h", h, 77);
        step();
        read_slot(1, v, x, h);
        chk("f80_slot1_x", x, 39);
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
          step();
          read_slot(i, v, x, h);
          nvalid += v;
        end
        chk("f80_pool_full", nvalid, 4);
      end
    end

    // Frame 81: second tick lands mid-pass and is dropped.
    frame_tick = 1'b1;
    step();
    step();
    frame_tick = 1'b0;
    repeat (5) step();
    chk("overrun_set", int'(overrun), 1);
    read_slot(0, v, x, h);
    chk("overrun_moved_once", x, 157);

    // Frame 82: enable falls mid-pass; pass completes, then ticks are ignored.
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    enable = 1'b0;
    b0 = busy_seen;
    repeat (6) step();
    chk("disable_pass_busy", busy_seen - b0, 4);
    b0 = busy_seen;
    repeat (3) frame();
    chk("idle_no_busy", busy_seen - b0, 0);
    read_slot(0, v, x, h);
    chk("idle_frozen_x", x, 155);
    enable = 1'b1;
    step();

    for (int f = 83; f <= 99; f++) frame();

    // Frame 100: slot2 would score on its update; restart arrives first.
    p0 = pulse_seen;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    repeat (4) step();
    chk("restart_no_pulse", pulse_seen - p0, 0);
    chk("restart_overrun_clr", int'(overrun), 0);
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      read_slot(i, v, x, h);
      nvalid += v;
      step();
    end
    chk("restart_all_invalid", nvalid, 0);

    height_in = 8'd60;
    frame();
    read_slot(0, v, x, h);
    chk("post_restart_valid", v, 1);
    chk("post_restart_x", x, 159);
    chk("post_restart_h", h, 60);
    step();
    read_slot(1, v, x, h);
    chk("post_restart_slot1", v, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
